instruction_sequencer: RTL and testbench
========================================

# instruction_sequencer

Multi-cycle fetch/decode/execute controller that drives the instruction decoder and gates its control outputs in time. It fetches 32-bit words from FLASH through a ready handshake and holds them in an instruction register feeding the decoder. It inserts a RAM read phase when an ALU operand comes from RAM, then issues one-cycle write strobes to REG1, REG2 and RAM. It also owns the program counter, including jump and halt handling.

## Interface
- ADDR_W, 8: FLASH address / PC width.
- RAM_LAT, 1: cycles RAM_RE is held before the EXEC phase (1..15).
- RESET_PC, 0: PC value after reset.
- CLK  in  1  single clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  level; leaves IDLE or HALT.
- FLASH_ADDR  out  ADDR_W  current PC.
- FLASH_RD  out  1  fetch request; held until FLASH_READY.
- FLASH_READY  in  1  FLASH_DATA valid this cycle.
- FLASH_DATA  in  32  fetched word.
- INSTRUCTION  out  32  instruction register, fed to the decoder.
- DEC_REG1_WR, DEC_REG2_WR, DEC_RAM_WR  in  1 each  decoder outputs.
- DEC_MUX_LEFT, DEC_MUX_RIGHT  in  2 each  decoder ALU mux selects; 2'b10 = RAM source.
- REG1_WE, REG2_WE, RAM_WE  out  1 each  gated write strobes.
- RAM_RE  out  1  RAM read enable.
- BUSY  out  1  high in FETCH/DECODE/MEM/EXEC.
- HALTED  out  1  high in HALT.

## Operation
- Sequencer control bits in INSTRUCTION[21:16]: bit 21 = HALT, bit 20 = JUMP; bits 19:16 are reserved and ignored.
- States: IDLE, FETCH, DECODE, MEM, EXEC, HALT.
- IDLE: when START=1, go to FETCH.
- FETCH: FLASH_RD=1 and FLASH_ADDR=PC. When FLASH_READY=1, INSTRUCTION<=FLASH_DATA and go to DECODE. With no FLASH_READY, stay in FETCH indefinitely.
- DECODE: exactly one cycle so the decoder outputs settle. If DEC_MUX_LEFT==2'b10 or DEC_MUX_RIGHT==2'b10, go to MEM; otherwise go to EXEC.
- MEM: RAM_RE=1 for RAM_LAT consecutive cycles, counted by an internal counter, then go to EXEC.
- EXEC: exactly one cycle. REG1_WE=DEC_REG1_WR, REG2_WE=DEC_REG2_WR, RAM_WE=DEC_RAM_WR. Outside EXEC all three are 0.
- PC update at the end of EXEC:
  - JUMP=1: PC<=INSTRUCTION[ADDR_W-1:0].
  - Otherwise: PC<=PC+1, modulo 2^ADDR_W. The top address wraps to 0 silently.
- Next state after EXEC: if HALT=1, go to HALT; otherwise go to FETCH.
- HALT and JUMP together: the jump target is loaded, then the block halts.
- HALT: no FLASH_RD and no strobes. START=1 goes to FETCH from the current PC.
- START is ignored outside IDLE and HALT.
- An all-zero instruction is a NOP: DECODE to EXEC with no strobes, PC+1.

## Timing
- Reset (asynchronous assert, synchronous deassert by the clock):
  - State=IDLE, PC=RESET_PC, INSTRUCTION=0, MEM counter=0.
  - FLASH_RD, RAM_RE, REG1_WE, REG2_WE, RAM_WE, BUSY and HALTED all 0.
- Reset asserted mid-instruction aborts it immediately; no strobe may be seen after RESET_N falls.
- All outputs are registered or decoded from the state register only; there are no combinational paths from FLASH_READY to the outputs.
- Instruction latency with FLASH_READY in the first FETCH cycle:
  - No RAM operand: 3 cycles (FETCH, DECODE, EXEC).
  - RAM operand: 3+RAM_LAT cycles.
- Each extra FLASH wait cycle adds 1.
- FLASH_ADDR is stable for the whole FETCH phase.
- FLASH_READY outside FETCH is ignored.
- RAM_RE and write strobes never overlap.
- At most one write strobe pulse per instruction, high for exactly 1 cycle.

## Test plan
- Reset then START with FLASH_READY tied 1 and NOPs at addresses 0..3 -> FLASH_ADDR steps 0,1,2,3 every 3 cycles; no strobes; BUSY=1.
- Instruction 32'h1000_0005 (REG1_WR) -> REG1_WE high for exactly 1 cycle, 2 cycles after FLASH_READY; PC 0->1.
- Instruction with DEC_MUX_RIGHT=2'b10, RAM_LAT=3 -> RAM_RE high for 3 cycles, then a 1-cycle EXEC strobe; total latency 6.
- JUMP to 8'hF0 with FLASH_READY delayed 4 cycles -> FLASH_RD held 5 cycles with FLASH_ADDR stable; next fetch at 8'hF0. PC at 8'hFF wraps to 8'h00.
- HALT instruction (bit 21) at PC=5 -> HALTED=1, BUSY=0, no FLASH_RD. START pulse -> fetch resumes at PC=6.
- RESET_N low during MEM -> RAM_RE drops asynchronously, state IDLE, PC=RESET_PC; no EXEC strobe follows.

Source files
------------

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetch/decode/mem/execute controller gating decoder write strobes and owning the PC
module instruction_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter int                RAM_LAT  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic [ADDR_W-1:0] flash_addr_o,
    output logic              flash_rd_o,
    input  logic              flash_ready_i,
    input  logic [31:0]       flash_data_i,
    output logic [31:0]       instruction_o,
    input  logic              dec_reg1_wr_i,
    input  logic              dec_reg2_wr_i,
    input  logic              dec_ram_wr_i,
    input  logic [1:0]        dec_mux_left_i,
    input  logic [1:0]        dec_mux_right_i,
    output logic              reg1_we_o,
    output logic              reg2_we_o,
    output logic              ram_we_o,
    output logic              ram_re_o,
    output logic              busy_o,
    output logic              halted_o
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALT} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              exec;

    // State, PC, instruction register and MEM counter; reset aborts any instruction in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; bit 21 of the instruction halts, bit 20 jumps to its low address bits
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_HALT: if (start_i) state_d = S_FETCH;
            S_FETCH: begin
                if (flash_ready_i) begin
                    ir_d    = flash_data_i;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = (dec_mux_left_i == 2'b10 || dec_mux_right_i == 2'b10) ? S_MEM : S_EXEC;
            S_MEM: begin
                if (cnt_q == 4'(RAM_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_EXEC: begin
                pc_d    = ir_q[20] ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
                state_d = ir_q[21] ? S_HALT : S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign exec          = state_q == S_EXEC;
    assign flash_addr_o  = pc_q;
    assign flash_rd_o    = state_q == S_FETCH;
    assign instruction_o = ir_q;
    assign ram_re_o      = state_q == S_MEM;
    assign reg1_we_o     = exec & dec_reg1_wr_i;
    assign reg2_we_o     = exec & dec_reg2_wr_i;
    assign ram_we_o      = exec & dec_ram_wr_i;
    assign busy_o        = state_q inside {S_FETCH, S_DECODE, S_MEM, S_EXEC};
    assign halted_o      = state_q == S_HALT;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed program run with a strobe scoreboard and a FLASH wait-state model
module tb_instruction_sequencer;
    logic        clk = 0;
    logic        rst_n, start;
    logic [7:0]  flash_addr;
    logic        flash_rd, flash_ready;
    logic [31:0] flash_data, instruction;
    logic        dec_reg1, dec_reg2, dec_ram;
    logic [1:0]  mux_l, mux_r;
    logic        reg1_we, reg2_we, ram_we, ram_re, busy, halted;

    logic [31:0] mem [256];
    int          wtab [256];
    int          wc = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [7:0] addr;
        logic [2:0] we;
        int         lat;
        int         rre;
    } exp_t;
    exp_t sb [$];

    int         f_cyc = 0;
    logic [7:0] f_addr = 0;
    int         rc = 0;

    instruction_sequencer #(.ADDR_W(8), .RAM_LAT(3), .RESET_PC(8'h00)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .flash_addr_o(flash_addr), .flash_rd_o(flash_rd), .flash_ready_i(flash_ready),
        .flash_data_i(flash_data), .instruction_o(instruction),
        .dec_reg1_wr_i(dec_reg1), .dec_reg2_wr_i(dec_reg2), .dec_ram_wr_i(dec_ram),
        .dec_mux_left_i(mux_l), .dec_mux_right_i(mux_r),
        .reg1_we_o(reg1_we), .reg2_we_o(reg2_we), .ram_we_o(ram_we),
        .ram_re_o(ram_re), .busy_o(busy), .halted_o(halted)
    );

    always #5 clk = ~clk;

    // decoder stand-in and FLASH with per-address wait states
    assign dec_reg1    = instruction[28];
    assign dec_reg2    = instruction[29];
    assign dec_ram     = instruction[30];
    assign mux_l       = instruction[25:24];
    assign mux_r       = instruction[27:26];
    assign flash_data  = mem[flash_addr];
    assign flash_ready = flash_rd && (wc >= wtab[flash_addr]);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        wc  <= (flash_rd && !flash_ready) ? wc + 1 : 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // strobe monitor: every strobe pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (flash_rd && flash_ready) begin
            f_addr = flash_addr;
            f_cyc  = cyc;
            rc     = 0;
        end
        if (ram_re) rc++;
        if (ram_re && (reg1_we || reg2_we || ram_we)) check("re_we_overlap", 1, 0);
        if (reg1_we || reg2_we || ram_we) begin
            if (sb.size() == 0) check("unexpected_strobe", {29'd0, reg1_we, reg2_we, ram_we}, 0);
            else begin
                e = sb.pop_front();
                check("sb_addr", f_addr, e.addr);
                check("sb_we", {29'd0, reg1_we, reg2_we, ram_we}, {29'd0, e.we});
                check("sb_lat", cyc - f_cyc, e.lat);
                check("sb_ram_re_cycles", rc, e.rre);
            end
        end
    end

    task automatic fetch_chk(input logic [7:0] ea, input int en, output int c);
        int n = 0;
        for (int k = 0; k < 100 && !flash_rd; k++) @(negedge clk);
        while (n < 100) begin
            check("fetch_addr", flash_addr, ea);
            check("fetch_busy", busy, 1);
            n++;
            if (flash_ready) break;
            @(negedge clk);
        end
        c = cyc;
        check("fetch_rd_cycles", n, en);
        @(negedge clk);
        check("ir_load", instruction, mem[ea]);
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        int c, p;
        rst_n = 0;
        start = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 0;
            wtab[i] = 0;
        end
        mem[4]    = 32'h1000_0005;
        mem[5]    = 32'h0020_0000;
        mem[6]    = 32'h2800_0000;
        mem[7]    = 32'h0010_00F0;
        wtab[7]   = 4;
        mem[8'hF0] = 32'h0010_00FF;
        mem[8'hFF] = 32'h1000_0000;
        sb.push_back('{addr: 8'h04, we: 3'b100, lat: 2, rre: 0});
        sb.push_back('{addr: 8'h06, we: 3'b010, lat: 5, rre: 3});
        sb.push_back('{addr: 8'hFF, we: 3'b100, lat: 2, rre: 0});
        sb.push_back('{addr: 8'h04, we: 3'b100, lat: 2, rre: 0});
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("rst_flash_rd", flash_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_ram_re", ram_re, 0);
        check("rst_we", {reg1_we, reg2_we, ram_we}, 0);
        check("rst_pc", flash_addr, 8'h00);
        check("rst_ir", instruction, 0);
        repeat (2) @(negedge clk);
        check("idle_no_fetch", flash_rd, 0);
        pulse_start();
        p = 0;
        for (int i = 0; i < 5; i++) begin
            fetch_chk(8'(i), 1, c);
            if (i > 0) check("nop_spacing", c - p, 3);
            p = c;
        end
        fetch_chk(8'h05, 1, c);
        check("spacing_before_halt", c - p, 3);
        repeat (2) @(negedge clk);
        check("halt_halted", halted, 1);
        check("halt_busy", busy, 0);
        check("halt_flash_rd", flash_rd, 0);
        check("halt_pc", flash_addr, 8'h06);
        repeat (3) @(negedge clk);
        check("halt_hold", {halted, flash_rd}, 2'b10);
        pulse_start();
        fetch_chk(8'h06, 1, c);
        check("resume_halted", halted, 0);
        fetch_chk(8'h07, 5, c);
        fetch_chk(8'hF0, 1, c);
        fetch_chk(8'hFF, 1, c);
        for (int i = 0; i < 6; i++) fetch_chk(8'(i), 1, c);
        repeat (2) @(negedge clk);
        check("halt2_halted", halted, 1);
        check("halt2_pc", flash_addr, 8'h06);
        pulse_start();
        fetch_chk(8'h06, 1, c);
        @(negedge clk);
        check("mem_ram_re", ram_re, 1);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("async_ram_re", ram_re, 0);
        check("async_busy", busy, 0);
        check("async_pc", flash_addr, 8'h00);
        check("async_ir", instruction, 0);
        repeat (3) @(negedge clk);
        check("rst_no_strobe", {reg1_we, reg2_we, ram_we}, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", {busy, flash_rd, halted}, 0);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
